palette_bank_ram: RTL and testbench

Runtime-loadable, multi-bank colour palette with a pipelined index→RGB lookup and a built-in brightness fade engine for screen transitions such as start screen → map → gym.
- Replaces hard-wired constant palette tables. Sprite, map, gym and start palettes become banks loaded over a write port.
- Sits between the per-pixel index generators and the VGA colour output.

---
 rtl/palette_bank_ram.sv | 187 ++++++++++++++++++
 tb/tb_palette_bank_ram.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/palette_bank_ram.sv
// Multi-bank runtime-loadable colour palette with a 2-stage index->RGB lookup
// and a brightness fade engine that scales every channel by the current level.
module palette_bank_ram #(
  parameter int NUM_BANKS = 4,
  parameter int INDEX_W   = 7,
  parameter int COLOR_W   = 24,
  parameter int LEVEL_W   = 4
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               wr_en,
  input  logic [2:0]         wr_bank,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [COLOR_W-1:0] wr_data,
  input  logic               rd_valid_in,
  input  logic [2:0]         bank_sel,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid_out,
  output logic [COLOR_W-1:0] color_out,
  input  logic               fade_start,
  input  logic               fade_dir,
  input  logic               fade_tick,
  output logic               fade_busy,
  output logic               fade_done,
  output logic [LEVEL_W:0]   level
);

  localparam int CH_W   = COLOR_W / 3;
  localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int DEPTH  = 2 ** (BANK_W + INDEX_W);
  localparam int PW     = CH_W + LEVEL_W + 1;
  localparam logic [3:0]       NB_LIM = 4'(NUM_BANKS);
  localparam logic [LEVEL_W:0] FULL   = {1'b1, {LEVEL_W{1'b0}}};
  localparam logic [LEVEL_W:0] LV_ZERO = {(LEVEL_W+1){1'b0}};
  localparam logic [LEVEL_W:0] LV_ONE  = {{LEVEL_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } state_t;

  // Per-channel (ch * lv) >> LEVEL_W; lv == FULL is an exact pass-through.
  function automatic logic [COLOR_W-1:0] scale_rgb(input logic [COLOR_W-1:0] c,
                                                   input logic [LEVEL_W:0]   lv);
    logic [PW-1:0]      p;
    logic [COLOR_W-1:0] r;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      p = PW'(c[k*CH_W +: CH_W]) * PW'(lv);
      r[k*CH_W +: CH_W] = CH_W'(p >> LEVEL_W);
    end
    return r;
  endfunction

  logic [COLOR_W-1:0]      r_mem [DEPTH];
  logic                    w_wr_ok;
  logic                    w_rd_ok;
  logic [BANK_W+INDEX_W-1:0] w_wr_addr;
  logic [BANK_W+INDEX_W-1:0] w_rd_addr;

  logic                    r_s1_valid;
  logic [COLOR_W-1:0]      r_s1_data;
  logic [LEVEL_W:0]        r_s1_level;
  logic                    r_valid_out;
  logic [COLOR_W-1:0]      r_color;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [LEVEL_W:0]        r_level;
  logic [LEVEL_W:0]        w_level_nxt;
  logic                    r_fade_done;
  logic                    w_done_nxt;

  // Out-of-range banks alias onto real storage, so both ports are gated here.
  assign w_wr_ok   = wr_en && ({1'b0, wr_bank} < NB_LIM);
  assign w_rd_ok   = {1'b0, bank_sel} < NB_LIM;
  assign w_wr_addr = {wr_bank[BANK_W-1:0], wr_index};
  assign w_rd_addr = {bank_sel[BANK_W-1:0], rd_index};

  // Palette storage write port (contents are deliberately not reset).
  always_ff @(posedge Clk) begin
    if (w_wr_ok) begin
      r_mem[w_wr_addr] <= wr_data;
    end
  end

  // Stage 1: fetch entry and capture the level that this pixel will use.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_level <= FULL;
    end else begin
      r_s1_valid <= rd_valid_in;
      if (rd_valid_in) begin
        r_s1_data  <= w_rd_ok ? r_mem[w_rd_addr] : '0;
        r_s1_level <= r_level;
      end
    end
  end

  // Stage 2: scale and register the output; colour holds while not valid.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_valid_out <= 1'b0;
      r_color     <= '0;
    end else begin
      r_valid_out <= r_s1_valid;
      if (r_s1_valid) begin
        r_color <= scale_rgb(r_s1_data, r_s1_level);
      end
    end
  end

  // Fade FSM next-state: an already-at-target fade finishes without ticks.
  always_comb begin
    w_state_nxt = r_state;
    w_level_nxt = r_level;
    w_done_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (fade_start) begin
          w_state_nxt = fade_dir ? FADE_IN : FADE_OUT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      FADE_OUT: begin
        if (r_level == LV_ZERO) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else if (fade_tick) begin
          w_level_nxt = r_level - LV_ONE;
          if (r_level == LV_ONE) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = FADE_OUT;
          end
        end else begin
          w_state_nxt = FADE_OUT;
        end
      end
      FADE_IN: begin
        if (r_level >= FULL) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else if (fade_tick) begin
          w_level_nxt = r_level + LV_ONE;
          if (r_level == (FULL - LV_ONE)) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = FADE_IN;
          end
        end else begin
          w_state_nxt = FADE_IN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_level_nxt = FULL;
      end
    endcase
  end

  // Fade FSM state, level and completion pulse registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= IDLE;
      r_level     <= FULL;
      r_fade_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_level     <= w_level_nxt;
      r_fade_done <= w_done_nxt;
    end
  end

  assign rd_valid_out = r_valid_out;
  assign color_out    = r_color;
  assign fade_busy    = (r_state != IDLE);
  assign fade_done    = r_fade_done;
  assign level        = r_level;

endmodule

// File: tb/tb_palette_bank_ram.sv
// Directed bench for palette_bank_ram: writes, pipelined reads, fades, reset.
module tb_palette_bank_ram;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_bank = 3'd0;
  logic [6:0]  wr_index = 7'd0;
  logic [23:0] wr_data = 24'd0;
  logic        rd_valid_in = 1'b0;
  logic [2:0]  bank_sel = 3'd0;
  logic [6:0]  rd_index = 7'd0;
  logic        rd_valid_out;
  logic [23:0] color_out;
  logic        fade_start = 1'b0;
  logic        fade_dir = 1'b0;
  logic        fade_tick = 1'b0;
  logic        fade_busy;
  logic        fade_done;
  logic [4:0]  level;

  int n_vec = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  palette_bank_ram #(
    .NUM_BANKS(4), .INDEX_W(7), .COLOR_W(24), .LEVEL_W(4)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_index(wr_index), .wr_data(wr_data),
    .rd_valid_in(rd_valid_in), .bank_sel(bank_sel), .rd_index(rd_index),
    .rd_valid_out(rd_valid_out), .color_out(color_out),
    .fade_start(fade_start), .fade_dir(fade_dir), .fade_tick(fade_tick),
    .fade_busy(fade_busy), .fade_done(fade_done), .level(level)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] b, input logic [6:0] i, input logic [23:0] d);
    wr_en = 1'b1; wr_bank = b; wr_index = i; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input logic [2:0] b, input logic [6:0] i,
                        input logic [23:0] exp, input string tag);
    bank_sel = b; rd_index = i; rd_valid_in = 1'b1;
    step();
    rd_valid_in = 1'b0;
    step();
    chk({tag, "_valid"}, 32'(rd_valid_out), 32'd1);
    chk(tag, 32'(color_out), 32'(exp));
  endtask

  task automatic ftick();
    fade_tick = 1'b1;
    step();
    fade_tick = 1'b0;
  endtask

  initial begin
    // Reset state
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_valid", 32'(rd_valid_out), 32'd0);
    chk("rst_color", 32'(color_out), 32'd0);
    chk("rst_busy", 32'(fade_busy), 32'd0);
    chk("rst_done", 32'(fade_done), 32'd0);
    chk("rst_level", 32'(level), 32'd16);
    step(); step();
    Reset_n = 1'b1;
    step();

    // Basic write/read, exact 2-cycle latency, back-to-back lookups
    wr(3'd1, 7'd5, 24'h6159A0);
    wr(3'd0, 7'd0, 24'h0080FF);
    bank_sel = 3'd1; rd_index = 7'd5; rd_valid_in = 1'b1;
    step();
    chk("lat1_valid", 32'(rd_valid_out), 32'd0);
    bank_sel = 3'd0; rd_index = 7'd0;
    step();
    rd_valid_in = 1'b0;
    chk("b2b_first_valid", 32'(rd_valid_out), 32'd1);
    chk("b2b_first", 32'(color_out), 32'h6159A0);
    step();
    chk("b2b_second_valid", 32'(rd_valid_out), 32'd1);
    chk("b2b_second", 32'(color_out), 32'h0080FF);
    step();
    chk("idle_valid", 32'(rd_valid_out), 32'd0);
    chk("idle_hold", 32'(color_out), 32'h0080FF);

    // Same-cycle write and read returns old data; next cycle sees new data
    wr(3'd2, 7'd3, 24'hAABBCC);
    wr_en = 1'b1; wr_bank = 3'd2; wr_index = 7'd3; wr_data = 24'h112233;
    bank_sel = 3'd2; rd_index = 7'd3; rd_valid_in = 1'b1;
    step();
    wr_en = 1'b0;
    step();
    rd_valid_in = 1'b0;
    chk("rw_old", 32'(color_out), 32'hAABBCC);
    step();
    chk("rw_new", 32'(color_out), 32'h112233);

    // Out-of-range bank reads and writes
    rd_chk(3'd1, 7'd5, 24'h6159A0, "pre_oob");
    rd_chk(3'd5, 7'd5, 24'h000000, "oob_read");
    wr(3'd0, 7'd9, 24'h111111);
    wr(3'd1, 7'd9, 24'h222222);
    wr(3'd2, 7'd9, 24'h333333);
    wr(3'd3, 7'd9, 24'h444444);
    wr(3'd4, 7'd9, 24'hABCDEF);
    wr(3'd6, 7'd9, 24'hABCDEF);
    rd_chk(3'd0, 7'd9, 24'h111111, "oob_wr_b0");
    rd_chk(3'd1, 7'd9, 24'h222222, "oob_wr_b1");
    rd_chk(3'd2, 7'd9, 24'h333333, "oob_wr_b2");
    rd_chk(3'd3, 7'd9, 24'h444444, "oob_wr_b3");

    // Fade out with an ignored fade-in request mid-way
    wr(3'd3, 7'd7, 24'hFF8040);
    rd_chk(3'd3, 7'd7, 24'hFF8040, "fade_full");
    fade_start = 1'b1; fade_dir = 1'b0;
    step();
    fade_start = 1'b0;
    chk("fo_busy", 32'(fade_busy), 32'd1);
    chk("fo_level0", 32'(level), 32'd16);
    repeat (4) ftick();
    chk("fo_level4", 32'(level), 32'd12);
    fade_start = 1'b1; fade_dir = 1'b1;
    step();
    fade_start = 1'b0;
    chk("fo_ign_busy", 32'(fade_busy), 32'd1);
    chk("fo_ign_level", 32'(level), 32'd12);
    repeat (4) ftick();
    chk("fo_level8", 32'(level), 32'd8);
    rd_chk(3'd3, 7'd7, 24'h7F4020, "fo_half");
    repeat (7) ftick();
    chk("fo_level15", 32'(level), 32'd1);
    chk("fo_nodone15", 32'(fade_done), 32'd0);
    rd_chk(3'd3, 7'd7, 24'h0F0804, "fo_lvl1");
    ftick();
    chk("fo_level16", 32'(level), 32'd0);
    chk("fo_done", 32'(fade_done), 32'd1);
    chk("fo_idle", 32'(fade_busy), 32'd0);
    step();
    chk("fo_done_once", 32'(fade_done), 32'd0);
    rd_chk(3'd3, 7'd7, 24'h000000, "fo_black");
    ftick();
    chk("idle_tick_level", 32'(level), 32'd0);
    chk("idle_tick_busy", 32'(fade_busy), 32'd0);

    // Fade in from black, then a zero-tick fade-in at full
    fade_start = 1'b1; fade_dir = 1'b1;
    step();
    fade_start = 1'b0;
    chk("fi_busy", 32'(fade_busy), 32'd1);
    repeat (15) ftick();
    chk("fi_level15", 32'(level), 32'd15);
    chk("fi_nodone", 32'(fade_done), 32'd0);
    ftick();
    chk("fi_level16", 32'(level), 32'd16);
    chk("fi_done", 32'(fade_done), 32'd1);
    chk("fi_idle", 32'(fade_busy), 32'd0);
    step();
    chk("fi_done_once", 32'(fade_done), 32'd0);
    rd_chk(3'd3, 7'd7, 24'hFF8040, "fi_full");
    fade_start = 1'b1; fade_dir = 1'b1;
    step();
    fade_start = 1'b0;
    chk("zt_busy", 32'(fade_busy), 32'd1);
    chk("zt_nodone", 32'(fade_done), 32'd0);
    step();
    chk("zt_done", 32'(fade_done), 32'd1);
    chk("zt_level", 32'(level), 32'd16);
    chk("zt_idle", 32'(fade_busy), 32'd0);
    step();
    chk("zt_done_once", 32'(fade_done), 32'd0);

    // Start and tick together: start taken, tick ignored; then async reset
    fade_start = 1'b1; fade_dir = 1'b0; fade_tick = 1'b1;
    step();
    fade_start = 1'b0; fade_tick = 1'b0;
    chk("st_level", 32'(level), 32'd16);
    chk("st_busy", 32'(fade_busy), 32'd1);
    repeat (9) ftick();
    chk("mid_level", 32'(level), 32'd7);
    bank_sel = 3'd3; rd_index = 7'd7; rd_valid_in = 1'b1;
    step(); step();
    chk("mid_valid", 32'(rd_valid_out), 32'd1);
    chk("mid_color", 32'(color_out), 32'h6F381C);
    #3 Reset_n = 1'b0;
    #1;
    chk("arst_color", 32'(color_out), 32'd0);
    chk("arst_valid", 32'(rd_valid_out), 32'd0);
    chk("arst_level", 32'(level), 32'd16);
    chk("arst_busy", 32'(fade_busy), 32'd0);
    chk("arst_done", 32'(fade_done), 32'd0);
    rd_valid_in = 1'b0;
    step();
    Reset_n = 1'b1;
    step();
    chk("post_valid", 32'(rd_valid_out), 32'd0);
    chk("post_level", 32'(level), 32'd16);
    chk("post_busy", 32'(fade_busy), 32'd0);
    chk("post_done", 32'(fade_done), 32'd0);
    step();
    chk("post_valid2", 32'(rd_valid_out), 32'd0);
    rd_chk(3'd3, 7'd7, 24'hFF8040, "post_read");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
